// File: rtl/data_memory_dumper.sv
// Debug-path reader: after a start request walks N_WORDS data-memory words from address 0
// and streams each one MSB-byte-first to the UART TX. Optional macro: DUMP_ADDR_PREFIX_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for i_start
// READ     | read enable and word address on the memory port
// LATCH    | memory data valid, captured into the shift register
// SEND     | o_tx_start pulse with the current byte on o_tx_data
// WAIT_TX  | holding the byte until the UART reports it finished
// DONE     | o_done pulse, word counter cleared
module data_memory_dumper #(
   parameter int NB_DATA = 32,
   parameter int NB_BYTE = 8,
   parameter int NB_ADDR = 5,
   parameter int N_WORDS = 32
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_start,
   output logic               o_mem_rd_en,
   output logic [NB_ADDR-1:0] o_mem_rd_addr,
   input  logic [NB_DATA-1:0] i_mem_rd_data,
   output logic [NB_BYTE-1:0] o_tx_data,
   output logic               o_tx_start,
   input  logic               i_tx_done,
   output logic               o_busy,
   output logic               o_done
);

   localparam int N_DATA_BYTES = NB_DATA / NB_BYTE;
`ifdef DUMP_ADDR_PREFIX_EN
   localparam int N_TX = N_DATA_BYTES + 1;
`else
   localparam int N_TX = N_DATA_BYTES;
`endif
   localparam int NB_IDX = $clog2(N_TX + 1);
   localparam logic [NB_IDX-1:0]  LAST_IDX  = NB_IDX'(N_TX - 1);
   localparam logic [NB_ADDR-1:0] LAST_WORD = NB_ADDR'(N_WORDS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_LATCH,
      ST_SEND,
      ST_WAIT_TX,
      ST_DONE
   } state_t;

   state_t             state, state_next;
   logic [NB_ADDR-1:0] word_cnt, word_cnt_next;
   logic [NB_IDX-1:0]  byte_idx, byte_idx_next;
   logic [NB_DATA-1:0] shreg, shreg_next;
   logic               rd_en_next, tx_start_next, busy_next, done_next;
   logic [NB_ADDR-1:0] rd_addr_next;
   logic [NB_BYTE-1:0] tx_data_next;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state         <= ST_IDLE;
         word_cnt      <= '0;
         byte_idx      <= '0;
         shreg         <= '0;
         o_mem_rd_en   <= 1'b0;
         o_mem_rd_addr <= '0;
         o_tx_data     <= '0;
         o_tx_start    <= 1'b0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
      end else begin
         state         <= state_next;
         word_cnt      <= word_cnt_next;
         byte_idx      <= byte_idx_next;
         shreg         <= shreg_next;
         o_mem_rd_en   <= rd_en_next;
         o_mem_rd_addr <= rd_addr_next;
         o_tx_data     <= tx_data_next;
         o_tx_start    <= tx_start_next;
         o_busy        <= busy_next;
         o_done        <= done_next;
      end
   end

   // Outputs are registered, so each branch sets the values for the state being entered.
   always_comb begin
      state_next    = state;
      word_cnt_next = word_cnt;
      byte_idx_next = byte_idx;
      shreg_next    = shreg;
      rd_en_next    = 1'b0;
      rd_addr_next  = o_mem_rd_addr;
      tx_data_next  = o_tx_data;
      tx_start_next = 1'b0;
      busy_next     = o_busy;
      done_next     = 1'b0;

      case (state)
         ST_IDLE: begin
            if (i_start) begin
               state_next   = ST_READ;
               rd_en_next   = 1'b1;
               rd_addr_next = word_cnt;
               busy_next    = 1'b1;
            end
         end
         ST_READ: begin
            state_next = ST_LATCH;
         end
         ST_LATCH: begin
            state_next    = ST_SEND;
            byte_idx_next = '0;
            tx_start_next = 1'b1;
`ifdef DUMP_ADDR_PREFIX_EN
            shreg_next    = i_mem_rd_data;
            tx_data_next  = NB_BYTE'(word_cnt);
`else
            shreg_next    = i_mem_rd_data << NB_BYTE;
            tx_data_next  = i_mem_rd_data[NB_DATA-1 -: NB_BYTE];
`endif
         end
         ST_SEND: begin
            state_next = ST_WAIT_TX;
         end
         ST_WAIT_TX: begin
            if (i_tx_done) begin
               if (byte_idx < LAST_IDX) begin
                  state_next    = ST_SEND;
                  byte_idx_next = byte_idx + NB_IDX'(1);
                  tx_start_next = 1'b1;
                  tx_data_next  = shreg[NB_DATA-1 -: NB_BYTE];
                  shreg_next    = shreg << NB_BYTE;
               end else if (word_cnt < LAST_WORD) begin
                  state_next    = ST_READ;
                  word_cnt_next = word_cnt + NB_ADDR'(1);
                  rd_en_next    = 1'b1;
                  rd_addr_next  = word_cnt + NB_ADDR'(1);
               end else begin
                  state_next = ST_DONE;
                  done_next  = 1'b1;
                  busy_next  = 1'b0;
               end
            end
         end
         ST_DONE: begin
            state_next    = ST_IDLE;
            word_cnt_next = '0;
            busy_next     = 1'b0;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_data_memory_dumper.sv
// Directed bench for data_memory_dumper: synchronous memory model, UART model answering
// tx_done five cycles after each tx_start, and per-scenario tasks with inline checks.
module tb_data_memory_dumper;

`ifdef DUMP_ADDR_PREFIX_EN
   localparam int BPW = 5;
`else
   localparam int BPW = 4;
`endif
   localparam int NWORDS = 32;
   localparam int TOTAL  = NWORDS * BPW;

   logic        clock = 1'b0;
   logic        rst   = 1'b1;
   logic        start = 1'b0;
   logic        mem_rd_en;
   logic [4:0]  mem_rd_addr;
   logic [31:0] mem_rd_data = '0;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_done;
   logic        busy;
   logic        done;

   logic [31:0] mem [NWORDS];

   int n_cmp = 0;
   int n_err = 0;

   int         cyc = 0;
   logic [7:0] tx_q[$];
   int         rd_addr_q[$];
   int         starts_per_word[$];
   int         done_cnt = 0;
   int         done_cyc = 0;
   int         last_txdone_cyc = 0;
   logic       busy_at_last_done = 1'b0;
   int         stable_err = 0;
   int         uart_cd = 0;
   logic       uart_done = 1'b0;
   logic       spur_done = 1'b0;
   logic       abuse = 1'b0;
   logic       prev_rd = 1'b0;

   assign tx_done = uart_done | spur_done;

   always #5 clock = ~clock;

   data_memory_dumper #(
      .NB_DATA(32), .NB_BYTE(8), .NB_ADDR(5), .N_WORDS(NWORDS)
   ) dut (
      .i_clock       (clock),
      .i_reset       (rst),
      .i_start       (start),
      .o_mem_rd_en   (mem_rd_en),
      .o_mem_rd_addr (mem_rd_addr),
      .i_mem_rd_data (mem_rd_data),
      .o_tx_data     (tx_data),
      .o_tx_start    (tx_start),
      .i_tx_done     (tx_done),
      .o_busy        (busy),
      .o_done        (done)
   );

   always @(posedge clock) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
   end

   // Monitor and UART model, evaluated 1 time unit after every rising edge.
   always begin
      @(posedge clock);
      #1;
      cyc = cyc + 1;
      uart_done = 1'b0;
      spur_done = 1'b0;
      if (tx_start) begin
         tx_q.push_back(tx_data);
         if (starts_per_word.size() > 0)
            starts_per_word[starts_per_word.size()-1] = starts_per_word[starts_per_word.size()-1] + 1;
         uart_cd = 5;
      end else if (uart_cd > 0) begin
         uart_cd = uart_cd - 1;
         if (uart_cd == 0) begin
            uart_done = 1'b1;
            last_txdone_cyc = cyc;
            busy_at_last_done = busy;
            if (tx_q.size() > 0 && tx_data !== tx_q[tx_q.size()-1]) stable_err = stable_err + 1;
         end
      end
      if (mem_rd_en) begin
         rd_addr_q.push_back(int'(mem_rd_addr));
         starts_per_word.push_back(0);
      end
      if (done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
      if (abuse && (mem_rd_en || prev_rd || tx_start)) spur_done = 1'b1;
      prev_rd = mem_rd_en;
   end

   function automatic logic [7:0] exp_byte(int i);
      int w;
      int k;
      logic [31:0] d;
      w = i / BPW;
      k = i % BPW;
      d = 32'hA0B0C000 + w;
`ifdef DUMP_ADDR_PREFIX_EN
      if (k == 0) return 8'(w);
      k = k - 1;
`endif
      return d[31-8*k -: 8];
   endfunction

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic clear_logs();
      tx_q.delete();
      rd_addr_q.delete();
      starts_per_word.delete();
      done_cnt = 0;
      stable_err = 0;
      uart_cd = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      n_cmp++;
      if ({mem_rd_en, mem_rd_addr, tx_data, tx_start, busy, done} !== 17'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got %h want 0", {mem_rd_en, mem_rd_addr, tx_data, tx_start, busy, done});
      end
      rst = 1'b0;
      step();
      clear_logs();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      n_cmp++;
      if (tx_start !== 1'b1 || tx_data === 8'd0) begin
         n_err++;
         $display("FAIL reset_pre_state: tx_start=%b tx_data=%h want 1 and nonzero", tx_start, tx_data);
      end
      #3 rst = 1'b1;
      #1;
      n_cmp++;
      if ({mem_rd_en, mem_rd_addr, tx_data, tx_start, busy, done} !== 17'd0) begin
         n_err++;
         $display("FAIL reset_async: got %h want 0", {mem_rd_en, mem_rd_addr, tx_data, tx_start, busy, done});
      end
      step();
      rst = 1'b0;
      repeat (4) step();
      n_cmp++;
      if (busy !== 1'b0 || mem_rd_en !== 1'b0 || tx_start !== 1'b0) begin
         n_err++;
         $display("FAIL reset_idle: busy=%b rd_en=%b tx_start=%b want 0", busy, mem_rd_en, tx_start);
      end
      repeat (8) step();
      clear_logs();
   endtask

   task automatic test_latency();
      clear_logs();
      start = 1'b1;
      step();
      start = 1'b0;
      n_cmp++;
      if (mem_rd_en !== 1'b1 || mem_rd_addr !== 5'd0) begin
         n_err++;
         $display("FAIL latency_c1: rd_en=%b addr=%0d want 1 0", mem_rd_en, mem_rd_addr);
      end
      step();
      n_cmp++;
      if (mem_rd_en !== 1'b0 || tx_start !== 1'b0) begin
         n_err++;
         $display("FAIL latency_c2: rd_en=%b tx_start=%b want 0 0", mem_rd_en, tx_start);
      end
      step();
      n_cmp++;
      if (tx_start !== 1'b1 || tx_data !== exp_byte(0) || busy !== 1'b1) begin
         n_err++;
         $display("FAIL latency_c3: tx_start=%b tx_data=%h busy=%b want 1 %h 1", tx_start, tx_data, busy, exp_byte(0));
      end
   endtask

   task automatic test_full_dump();
      for (int i = 0; i < 3000 && done_cnt == 0; i++) step();
      n_cmp++;
      if (done_cnt == 0) begin
         n_err++;
         $display("FAIL full_timeout: no o_done within budget");
      end
      repeat (10) step();
      n_cmp++;
      if (tx_q.size() != TOTAL) begin
         n_err++;
         $display("FAIL full_byte_count: got %0d want %0d", tx_q.size(), TOTAL);
      end
      for (int i = 0; i < TOTAL && i < tx_q.size(); i++) begin
         n_cmp++;
         if (tx_q[i] !== exp_byte(i)) begin
            n_err++;
            $display("FAIL full_byte[%0d]: got %h want %h", i, tx_q[i], exp_byte(i));
         end
      end
      n_cmp++;
      if (rd_addr_q.size() != NWORDS) begin
         n_err++;
         $display("FAIL full_read_count: got %0d want %0d", rd_addr_q.size(), NWORDS);
      end
      for (int i = 0; i < rd_addr_q.size(); i++) begin
         n_cmp++;
         if (rd_addr_q[i] != i || starts_per_word[i] != BPW) begin
            n_err++;
            $display("FAIL full_word[%0d]: addr=%0d starts=%0d want %0d %0d", i, rd_addr_q[i], starts_per_word[i], i, BPW);
         end
      end
      n_cmp++;
      if (done_cnt != 1 || done_cyc != last_txdone_cyc + 1) begin
         n_err++;
         $display("FAIL full_done: pulses=%0d at %0d want 1 at %0d", done_cnt, done_cyc, last_txdone_cyc + 1);
      end
      n_cmp++;
      if (busy_at_last_done !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         n_err++;
         $display("FAIL full_busy: at_last_done=%b after=%b done=%b want 1 0 0", busy_at_last_done, busy, done);
      end
      n_cmp++;
      if (stable_err != 0) begin
         n_err++;
         $display("FAIL full_tx_stable: %0d bytes changed before tx_done, want 0", stable_err);
      end
   endtask

   task automatic test_protocol_abuse();
      clear_logs();
      abuse = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
         if (i % 23 == 7 && busy) begin
            start = 1'b1;
            step();
            start = 1'b0;
         end else begin
            step();
         end
      end
      abuse = 1'b0;
      repeat (20) step();
      n_cmp++;
      if (done_cnt != 1) begin
         n_err++;
         $display("FAIL abuse_done: pulses=%0d want 1", done_cnt);
      end
      n_cmp++;
      if (tx_q.size() != TOTAL || rd_addr_q.size() != NWORDS) begin
         n_err++;
         $display("FAIL abuse_counts: bytes=%0d reads=%0d want %0d %0d", tx_q.size(), rd_addr_q.size(), TOTAL, NWORDS);
      end
      for (int i = 0; i < TOTAL && i < tx_q.size(); i++) begin
         n_cmp++;
         if (tx_q[i] !== exp_byte(i)) begin
            n_err++;
            $display("FAIL abuse_byte[%0d]: got %h want %h", i, tx_q[i], exp_byte(i));
         end
      end
   endtask

   task automatic test_reset_mid_dump();
      clear_logs();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 500 && tx_q.size() < 10; i++) step();
      n_cmp++;
      if (tx_q.size() != 10) begin
         n_err++;
         $display("FAIL mid_reach10: bytes=%0d want 10", tx_q.size());
      end
      #3 rst = 1'b1;
      #1;
      n_cmp++;
      if ({mem_rd_en, tx_start, busy, done} !== 4'd0) begin
         n_err++;
         $display("FAIL mid_async: rd_en/tx_start/busy/done=%b want 0000", {mem_rd_en, tx_start, busy, done});
      end
      step();
      rst = 1'b0;
      repeat (20) step();
      n_cmp++;
      if (done_cnt != 0 || tx_q.size() != 10 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL mid_quiet: done=%0d bytes=%0d busy=%b want 0 10 0", done_cnt, tx_q.size(), busy);
      end
      clear_logs();
      start = 1'b1;
      step();
      start = 1'b0;
      n_cmp++;
      if (mem_rd_en !== 1'b1 || mem_rd_addr !== 5'd0) begin
         n_err++;
         $display("FAIL mid_restart_addr: rd_en=%b addr=%0d want 1 0", mem_rd_en, mem_rd_addr);
      end
      step();
      step();
      n_cmp++;
      if (tx_start !== 1'b1 || tx_data !== exp_byte(0)) begin
         n_err++;
         $display("FAIL mid_restart_byte: tx_start=%b tx_data=%h want 1 %h", tx_start, tx_data, exp_byte(0));
      end
      for (int i = 0; i < 3000 && done_cnt == 0; i++) step();
      step();
      n_cmp++;
      if (done_cnt != 1 || tx_q.size() != TOTAL) begin
         n_err++;
         $display("FAIL mid_restart_full: done=%0d bytes=%0d want 1 %0d", done_cnt, tx_q.size(), TOTAL);
      end
   endtask

   initial begin
      for (int k = 0; k < NWORDS; k++) mem[k] = 32'hA0B0C000 + k;
      test_reset();
      test_latency();
      test_full_dump();
      test_protocol_abuse();
      test_reset_mid_dump();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
